traffic_phase_controller: RTL and testbench



---
 rtl/traffic_pkg.sv | 27 ++
 rtl/tick_prescaler.sv | 29 ++
 rtl/traffic_phase_controller.sv | 134 +++++++++++++
 tb/tb_traffic_phase_controller.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared light encodings, state encoding and head bundle for the
// sensor-actuated four-head traffic phase controller.
package traffic_pkg;

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;
  localparam logic [2:0] LT_OFF = 3'b000;

  typedef enum logic [2:0] {
    ST_MAIN_GO  = 3'd0,
    ST_M2_YEL   = 3'd1,
    ST_TURN_GO  = 3'd2,
    ST_TURN_YEL = 3'd3,
    ST_SIDE_GO  = 3'd4,
    ST_SIDE_YEL = 3'd5,
    ST_FLASH    = 3'd6
  } state_e;

  typedef struct packed {
    logic [2:0] m1;
    logic [2:0] m2;
    logic [2:0] mt;
    logic [2:0] s;
  } heads_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock into a one-cycle tick strobe every TICK_DIV cycles;
// with TICK_DIV=1 the strobe is permanently high.
module tick_prescaler #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  // NOTE: sequential state uses non-blocking assignment only; the next value
  // is computed in always_comb so the flop block stays a plain register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/traffic_phase_controller.sv
// Moore phase controller for four signal heads: timed main/turn phases, a
// side-street phase served on latched demand, and a night flash mode.
module traffic_phase_controller
  import traffic_pkg::*;
#(
  parameter int TICK_DIV = 1,
  parameter int TW       = 8,
  parameter int T_MAIN   = 7,
  parameter int T_TURN   = 5,
  parameter int T_SIDE   = 3,
  parameter int T_Y      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       side_req,
  input  logic       flash_en,
  output logic [2:0] light_M1,
  output logic [2:0] light_M2,
  output logic [2:0] light_MT,
  output logic [2:0] light_S,
  output logic [2:0] phase,
  output logic       tick
);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          demand_q, demand_d;
  logic          blink_q, blink_d;
  logic [TW-1:0] timer_last;
  logic          expire;
  state_e        main_dest;
  heads_t        heads;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_comb begin
    timer_last = '0;
    case (state_q)
      ST_MAIN_GO:                          timer_last = TW'(T_MAIN - 1);
      ST_TURN_GO:                          timer_last = TW'(T_TURN - 1);
      ST_SIDE_GO:                          timer_last = TW'(T_SIDE - 1);
      ST_M2_YEL, ST_TURN_YEL, ST_SIDE_YEL: timer_last = TW'(T_Y - 1);
      default:                             timer_last = '0;
    endcase
  end

  assign expire    = tick && (timer_q == timer_last);
  // Only transitions headed for MAIN_GO are diverted into night flash.
  assign main_dest = flash_en ? ST_FLASH : ST_MAIN_GO;

  // NOTE: every always_comb output gets a default first so no path through
  // the case statement can leave a value held, which would infer a latch.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    blink_d  = 1'b1;
    demand_d = demand_q | side_req;
    case (state_q)
      ST_MAIN_GO, ST_M2_YEL, ST_TURN_GO, ST_TURN_YEL, ST_SIDE_GO, ST_SIDE_YEL: begin
        if (expire) begin
          timer_d = '0;
          case (state_q)
            ST_MAIN_GO:  state_d = ST_M2_YEL;
            ST_M2_YEL:   state_d = ST_TURN_GO;
            ST_TURN_GO:  state_d = ST_TURN_YEL;
            ST_TURN_YEL: state_d = demand_q ? ST_SIDE_GO : main_dest;
            ST_SIDE_GO:  state_d = ST_SIDE_YEL;
            default:     state_d = main_dest;
          endcase
        end else if (tick) begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_FLASH: begin
        timer_d = '0;
        blink_d = blink_q;
        if (tick) begin
          if (!flash_en) begin
            state_d = ST_MAIN_GO;
            blink_d = 1'b1;
          end else begin
            blink_d = ~blink_q;
          end
        end
      end
      default: begin
        state_d = ST_MAIN_GO;
        timer_d = '0;
      end
    endcase
    // Entering SIDE_GO consumes the request, even one arriving this same cycle.
    if (state_d == ST_SIDE_GO && state_q != ST_SIDE_GO) demand_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_MAIN_GO;
      timer_q  <= '0;
      demand_q <= 1'b0;
      blink_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      demand_q <= demand_d;
      blink_q  <= blink_d;
    end
  end

  always_comb begin
    heads = '{m1: LT_RED, m2: LT_RED, mt: LT_RED, s: LT_RED};
    case (state_q)
      ST_MAIN_GO:  heads = '{m1: LT_GRN, m2: LT_GRN, mt: LT_RED, s: LT_RED};
      ST_M2_YEL:   heads = '{m1: LT_GRN, m2: LT_YEL, mt: LT_RED, s: LT_RED};
      ST_TURN_GO:  heads = '{m1: LT_GRN, m2: LT_RED, mt: LT_GRN, s: LT_RED};
      ST_TURN_YEL: heads = '{m1: LT_YEL, m2: LT_RED, mt: LT_YEL, s: LT_RED};
      ST_SIDE_GO:  heads = '{m1: LT_RED, m2: LT_RED, mt: LT_RED, s: LT_GRN};
      ST_SIDE_YEL: heads = '{m1: LT_RED, m2: LT_RED, mt: LT_RED, s: LT_YEL};
      ST_FLASH:    heads = blink_q ? '{m1: LT_YEL, m2: LT_YEL, mt: LT_RED, s: LT_RED}
                                   : '{m1: LT_OFF, m2: LT_OFF, mt: LT_OFF, s: LT_OFF};
      default:     heads = '{m1: LT_RED, m2: LT_RED, mt: LT_RED, s: LT_RED};
    endcase
  end

  assign light_M1 = heads.m1;
  assign light_M2 = heads.m2;
  assign light_MT = heads.mt;
  assign light_S  = heads.s;
  assign phase    = state_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed bench for traffic_phase_controller: default sequence, side demand,
// night flash, TICK_DIV=4 timing and mid-phase reset.
module tb_traffic_phase_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       side_req = 1'b0;
  logic       flash_en = 1'b0;
  logic [2:0] m1_a, m2_a, mt_a, s_a, phase_a;
  logic       tick_a;
  logic [2:0] m1_b, m2_b, mt_b, s_b, phase_b;
  logic       tick_b;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] ph;
    logic       bl;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  traffic_phase_controller #(.TICK_DIV(1)) dut (
    .clk(clk), .rst(rst), .side_req(side_req), .flash_en(flash_en),
    .light_M1(m1_a), .light_M2(m2_a), .light_MT(mt_a), .light_S(s_a),
    .phase(phase_a), .tick(tick_a)
  );

  traffic_phase_controller #(.TICK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .side_req(side_req), .flash_en(flash_en),
    .light_M1(m1_b), .light_M2(m2_b), .light_MT(mt_b), .light_S(s_b),
    .phase(phase_b), .tick(tick_b)
  );

  // Head table M1/M2/MT/S per phase; FLASH depends on the blink bit.
  function automatic logic [11:0] exp_lights(input logic [2:0] ph, input logic bl);
    case (ph)
      3'd0: return {3'b001, 3'b001, 3'b100, 3'b100};
      3'd1: return {3'b001, 3'b010, 3'b100, 3'b100};
      3'd2: return {3'b001, 3'b100, 3'b001, 3'b100};
      3'd3: return {3'b010, 3'b100, 3'b010, 3'b100};
      3'd4: return {3'b100, 3'b100, 3'b100, 3'b001};
      3'd5: return {3'b100, 3'b100, 3'b100, 3'b010};
      3'd6: return bl ? {3'b010, 3'b010, 3'b100, 3'b100} : 12'h000;
      default: return 12'hfff;
    endcase
  endfunction

  task automatic push_seg(input logic [2:0] ph, input int n);
    repeat (n) exp_q.push_back('{ph: ph, bl: 1'b1});
  endtask

  task automatic push_plain_cycle(input bit with_side);
    push_seg(3'd0, 7); push_seg(3'd1, 2); push_seg(3'd2, 5); push_seg(3'd3, 2);
    if (with_side) begin
      push_seg(3'd4, 3); push_seg(3'd5, 2);
    end
  endtask

  // Leaves the bench at the falling edge just after reset is released.
  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; side_req = 1'b1; flash_en = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (phase_a !== 3'd0) begin
      failures++; $display("FAIL reset_phase got=%0d exp=0", phase_a);
    end
    checks++;
    if ({m1_a, m2_a, mt_a, s_a} !== exp_lights(3'd0, 1'b1)) begin
      failures++; $display("FAIL reset_lights got=%h exp=%h", {m1_a, m2_a, mt_a, s_a}, exp_lights(3'd0, 1'b1));
    end
    checks++;
    if (tick_a !== 1'b1) begin
      failures++; $display("FAIL reset_tick_div1 got=%b exp=1", tick_a);
    end
    checks++;
    if (tick_b !== 1'b0 || phase_b !== 3'd0) begin
      failures++; $display("FAIL reset_div4 got tick=%b phase=%0d exp tick=0 phase=0", tick_b, phase_b);
    end
    side_req = 1'b0; flash_en = 1'b0;
  endtask

  task automatic test_default_cycle();
    exp_q.delete();
    push_plain_cycle(1'b0); push_plain_cycle(1'b0); push_seg(3'd0, 1);
    apply_reset();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (phase_a !== exp_q[i].ph) begin
        failures++; $display("FAIL default_phase[%0d] got=%0d exp=%0d", i, phase_a, exp_q[i].ph);
      end
      checks++;
      if ({m1_a, m2_a, mt_a, s_a} !== exp_lights(exp_q[i].ph, exp_q[i].bl)) begin
        failures++; $display("FAIL default_lights[%0d] got=%h exp=%h", i, {m1_a, m2_a, mt_a, s_a}, exp_lights(exp_q[i].ph, exp_q[i].bl));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_side_pulse();
    exp_q.delete();
    push_plain_cycle(1'b1); push_plain_cycle(1'b0); push_seg(3'd0, 1);
    apply_reset();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (phase_a !== exp_q[i].ph) begin
        failures++; $display("FAIL side_pulse_phase[%0d] got=%0d exp=%0d", i, phase_a, exp_q[i].ph);
      end
      checks++;
      if ({m1_a, m2_a, mt_a, s_a} !== exp_lights(exp_q[i].ph, exp_q[i].bl)) begin
        failures++; $display("FAIL side_pulse_lights[%0d] got=%h exp=%h", i, {m1_a, m2_a, mt_a, s_a}, exp_lights(exp_q[i].ph, exp_q[i].bl));
      end
      side_req = (i == 10);
      @(negedge clk);
    end
    side_req = 1'b0;
  endtask

  task automatic test_side_held();
    exp_q.delete();
    push_plain_cycle(1'b1); push_plain_cycle(1'b1); push_seg(3'd0, 1);
    side_req = 1'b1;
    apply_reset();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (phase_a !== exp_q[i].ph) begin
        failures++; $display("FAIL side_held_phase[%0d] got=%0d exp=%0d", i, phase_a, exp_q[i].ph);
      end
      @(negedge clk);
    end
    side_req = 1'b0;
  endtask

  task automatic test_flash();
    exp_q.delete();
    push_plain_cycle(1'b0);
    for (int k = 0; k < 6; k++) exp_q.push_back('{ph: 3'd6, bl: (k % 2 == 0)});
    push_seg(3'd0, 7); push_seg(3'd1, 1);
    apply_reset();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (phase_a !== exp_q[i].ph) begin
        failures++; $display("FAIL flash_phase[%0d] got=%0d exp=%0d", i, phase_a, exp_q[i].ph);
      end
      checks++;
      if ({m1_a, m2_a, mt_a, s_a} !== exp_lights(exp_q[i].ph, exp_q[i].bl)) begin
        failures++; $display("FAIL flash_lights[%0d] got=%h exp=%h", i, {m1_a, m2_a, mt_a, s_a}, exp_lights(exp_q[i].ph, exp_q[i].bl));
      end
      if (i == 10) flash_en = 1'b1;
      if (i == 21) flash_en = 1'b0;
      @(negedge clk);
    end
    flash_en = 1'b0;
  endtask

  task automatic test_tick_div4();
    exp_q.delete();
    push_seg(3'd0, 28); push_seg(3'd1, 8); push_seg(3'd2, 20); push_seg(3'd3, 8); push_seg(3'd0, 1);
    apply_reset();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (phase_b !== exp_q[i].ph) begin
        failures++; $display("FAIL div4_phase[%0d] got=%0d exp=%0d", i, phase_b, exp_q[i].ph);
      end
      checks++;
      if (tick_b !== (i % 4 == 3)) begin
        failures++; $display("FAIL div4_tick[%0d] got=%b exp=%b", i, tick_b, (i % 4 == 3));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_side();
    exp_q.delete();
    push_plain_cycle(1'b0); push_seg(3'd4, 3);
    push_plain_cycle(1'b0); push_seg(3'd0, 1);
    side_req = 1'b1;
    apply_reset();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (phase_a !== exp_q[i].ph) begin
        failures++; $display("FAIL rst_mid_phase[%0d] got=%0d exp=%0d", i, phase_a, exp_q[i].ph);
      end
      checks++;
      if ({m1_a, m2_a, mt_a, s_a} !== exp_lights(exp_q[i].ph, exp_q[i].bl)) begin
        failures++; $display("FAIL rst_mid_lights[%0d] got=%h exp=%h", i, {m1_a, m2_a, mt_a, s_a}, exp_lights(exp_q[i].ph, exp_q[i].bl));
      end
      if (i == 18) rst = 1'b1;
      if (i == 19) begin
        rst = 1'b0; side_req = 1'b0;
      end
      @(negedge clk);
    end
    side_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_default_cycle();
    test_side_pulse();
    test_side_held();
    test_flash();
    test_tick_div4();
    test_reset_mid_side();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
